// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: 8-bit unsigned dividend by 4-bit unsigned
// divisor, one quotient bit per clock, MSB first. A zero divisor skips the
// iteration and reports quotient 8'hFF, remainder 0 with div_by_zero set.
module seq_restoring_divider (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [7:0]  dvd_q, dvd_d;     // dividend bits still to consume; quotient bits shift in at LSB
  logic [3:0]  dvs_q, dvs_d;     // captured divisor
  logic [4:0]  prem_q, prem_d;   // partial remainder
  logic [2:0]  cnt_q, cnt_d;     // iteration counter
  logic [7:0]  quot_q, quot_d;
  logic [3:0]  rem_q, rem_d;
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  logic        accept;
  logic        zero_publish;
  logic [4:0]  shifted;
  logic [4:0]  step;
  logic        qbit;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    shifted = {prem_q[3:0], dvd_q[7]};
    qbit    = (shifted >= {1'b0, dvs_q});
    step    = qbit ? (shifted - {1'b0, dvs_q}) : shifted;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    accept       = start && ((state_q == IDLE) || (state_q == DONE));
    // A zero-divisor operation spends its single DONE cycle publishing the
    // result, so done rises one edge after acceptance without touching CALC.
    zero_publish = (state_q == DONE) && (dvs_q == 4'd0);

    case (state_q)
      IDLE: ;
      CALC: begin
        prem_d = step;
        dvd_d  = {dvd_q[6:0], qbit};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = DONE;
          quot_d  = {dvd_q[6:0], qbit};
          rem_d   = step[3:0];
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      dvd_d   = dividend;
      dvs_d   = divisor;
      prem_d  = '0;
      cnt_d   = '0;
      dbz_d   = 1'b0;
      state_d = (divisor == 4'd0) ? DONE : CALC;
    end

    // Publishing the old zero-divisor result takes priority over the clear
    // from a back-to-back accept on the same edge.
    if (zero_publish) begin
      quot_d = '1;
      rem_d  = '0;
      dbz_d  = 1'b1;
      done_d = 1'b1;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = (state_q == CALC);
  assign done        = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed self-checking bench for seq_restoring_divider.
module tb_seq_restoring_divider;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int unsigned n_cmp;
  int unsigned n_bad;

  seq_restoring_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  // Called just after the accept edge (#1). Returns edges until done is seen
  // and how many samples had busy high before that.
  task automatic wait_done(input int max, output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < max) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Drive one operation, scramble the operand inputs after acceptance,
  // then check result, latency, busy length and done pulse width.
  task automatic do_op(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] eq, input logic [3:0] er,
                       input logic edbz, input int elat, input int ebusy);
    int lat, bc;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    wait_done(20, lat, bc);
    chk($sformatf("latency %0d/%0d", a, b), 16'(lat), 16'(elat));
    chk($sformatf("busy_cycles %0d/%0d", a, b), 16'(bc), 16'(ebusy));
    chk($sformatf("quot %0d/%0d", a, b), 16'(quotient), 16'(eq));
    chk($sformatf("rem %0d/%0d", a, b), 16'(remainder), 16'(er));
    chk($sformatf("dbz %0d/%0d", a, b), 16'(div_by_zero), 16'(edbz));
    @(posedge clk); #1;
    chk($sformatf("done_width %0d/%0d", a, b), 16'(done), 16'd0);
  endtask

  initial begin
    int lat, bc, dcnt;
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_quot", 16'(quotient), 16'd0);
    chk("rst_rem", 16'(remainder), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_done", 16'(done), 16'd0);
    chk("rst_dbz", 16'(div_by_zero), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic and boundary operands
    do_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8, 8);
    do_op(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8, 8);
    do_op(8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 8, 8);
    do_op(8'd0, 4'd15, 8'd0, 4'd0, 1'b0, 8, 8);
    do_op(8'd100, 4'd0, 8'hFF, 4'd0, 1'b1, 1, 0);
    do_op(8'd15, 4'd15, 8'd1, 4'd0, 1'b0, 8, 8);

    // Start during busy ignored, then back-to-back start held in DONE
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b1; dividend = 8'd255; divisor = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(20, lat, bc);
    chk("ign_latency", 16'(lat + 3), 16'd8);
    chk("ign_busy_cycles", 16'(bc + 3), 16'd8);
    chk("ign_quot", 16'(quotient), 16'd28);
    chk("ign_rem", 16'(remainder), 16'd4);
    start = 1'b1; dividend = 8'd255; divisor = 4'd15;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done_drop", 16'(done), 16'd0);
    chk("b2b_busy", 16'(busy), 16'd1);
    wait_done(20, lat, bc);
    chk("b2b_latency", 16'(lat), 16'd8);
    chk("b2b_quot", 16'(quotient), 16'd17);
    chk("b2b_rem", 16'(remainder), 16'd0);
    @(posedge clk); #1;

    // Reset mid-CALC aborts without a done pulse
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 4'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_quot", 16'(quotient), 16'd0);
    chk("abort_rem", 16'(remainder), 16'd0);
    chk("abort_busy", 16'(busy), 16'd0);
    chk("abort_done", 16'(done), 16'd0);
    chk("abort_dbz", 16'(div_by_zero), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dcnt++;
    end
    chk("abort_no_done", 16'(dcnt), 16'd0);
    do_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8, 8);

    // Full sweep of dividends and nonzero divisors
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        do_op(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 8, 8);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
